// File: rtl/seq_det_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl_pkg
// Shared definitions for the serial sequence-detector sequencer.
//   state_t       : sequencer FSM states (2-bit encoding)
//   DEFAULT_WIDTH : default word width in bits
//   last_index    : helper returning the index of the final shifted bit
// -----------------------------------------------------------------------------
package seq_det_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Index of the last bit shifted out of a word of the given width.
  function automatic int last_index(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Sequencer for an external serial Mealy sequence detector. A parallel word is
// accepted over in_valid/in_ready, shifted MSB-first into the detector one bit
// per clock, and the detector's output is recorded per bit into a hit mask that
// is returned over out_valid/out_ready. The detector is held in reset whenever
// no word is being shifted, so each word is scanned from the detector's initial
// state and nothing carries across word boundaries.
//
// Optional feature macro: SEQ_DET_HIT_COUNT_EN
//   defined     -> out_count port present, counts ones in out_hits
//   not defined -> out_count port and counter absent
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   in_valid   in   1      word available on in_data
//   in_ready   out  1      sequencer can accept a word (registered)
//   in_data    in   WIDTH  word to scan, sampled only on accept
//   det_din    out  1      serial bit to the detector (registered)
//   det_rst    out  1      detector reset, active high (registered)
//   det_dout   in   1      detector Mealy output for the current det_din
//   out_valid  out  1      result available (registered)
//   out_ready  in   1      consumer takes the result
//   out_hits   out  WIDTH  out_hits[WIDTH-1-i] = detector output for bit i
//   out_count  out  CNT_W  number of ones in out_hits (feature macro only)
// -----------------------------------------------------------------------------
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_din,
  output logic             det_rst,
  input  logic             det_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hits
`ifdef SEQ_DET_HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(last_index(WIDTH));
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] idx_r;
  logic [WIDTH-1:0] hits_r;
  logic             in_ready_r;
  logic             det_rst_r;
  logic             det_din_r;
  logic             out_valid_r;

  // FSM, shift datapath and all handshake/detector outputs, registered together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      shreg_r     <= '0;
      idx_r       <= '0;
      hits_r      <= '0;
      in_ready_r  <= 1'b1;
      det_rst_r   <= 1'b1;
      det_din_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // in_ready_r is always 1 in IDLE, so in_valid alone is the accept.
            // det_rst drops on this edge so the detector leaves reset exactly
            // when the first bit is presented.
            state_r    <= SHIFT;
            shreg_r    <= in_data;
            idx_r      <= '0;
            hits_r     <= '0;
            in_ready_r <= 1'b0;
            det_rst_r  <= 1'b0;
            det_din_r  <= in_data[WIDTH-1];
          end
        end
        SHIFT: begin
          // det_dout belongs to the bit currently on det_din.
          hits_r  <= {hits_r[WIDTH-2:0], det_dout};
          shreg_r <= shreg_r << 1;
          idx_r   <= idx_r + CNT_ONE;
          if (idx_r == LAST_IDX) begin
            state_r     <= DONE;
            det_rst_r   <= 1'b1;
            det_din_r   <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            // Pre-load the next bit so det_din is a clean register output.
            det_din_r <= shreg_r[WIDTH-2];
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          det_rst_r   <= 1'b1;
          det_din_r   <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign det_rst   = det_rst_r;
  assign det_din   = det_din_r;
  assign out_valid = out_valid_r;
  assign out_hits  = hits_r;

`ifdef SEQ_DET_HIT_COUNT_EN
  logic [CNT_W-1:0] count_r;

  // Hit counter: cleared on accept, incremented for every hit while shifting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if ((state_r == IDLE) && in_valid) begin
      count_r <= '0;
    end else if ((state_r == SHIFT) && det_dout) begin
      // At most WIDTH increments per word, which CNT_W always holds.
      count_r <= count_r + CNT_ONE;
    end
  end

  assign out_count = count_r;
`endif

endmodule
